// File: rtl/button_debounce_if_pkg.sv
// Shared definitions for the memory-mapped push-button interface.
// Provides the read-select encodings, the data-bus width and the default
// debounce length used by the button block and its bus interface.
package btn_if_pkg;

  localparam int   XLEN                = 32;
  localparam logic BTN_SEL_LEVEL       = 1'b0;
  localparam logic BTN_SEL_EVENT       = 1'b1;
  localparam int   DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/button_debounce_if_if.sv
// Load-path bus between the core's I/O space and the button block.
//   rd_en  : read strobe (a read with rd_sel=event clears pending events)
//   rd_sel : BTN_SEL_LEVEL / BTN_SEL_EVENT
//   data   : XLEN-bit combinational read data
//   irq    : press-event interrupt request
// master = core side, slave = button block.
interface btn_bus_if;
  import btn_if_pkg::*;

  logic            rd_en;
  logic            rd_sel;
  logic [XLEN-1:0] data;
  logic            irq;

  modport master (output rd_en, output rd_sel, input data, input irq);
  modport slave  (input rd_en, input rd_sel, output data, output irq);

endinterface

// File: rtl/button_debounce_if_channel.sv
// One button channel: 2-flop synchroniser followed by a counter debouncer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   btn_raw  : raw asynchronous button input
//   deb      : debounced level
//   rise     : high in the cycle whose clock edge moves deb from 0 to 1
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic deb,
  output logic rise
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s0_d  = btn_raw;
    s1_d  = s0_q;
    deb_d = deb_q;
    cnt_d = '0;
    // Count only while the synchronised level disagrees; any agreement
    // drops the partial count so short glitches never reach deb.
    if (s1_q != deb_q) begin
      if (cnt_q == CNT_TERM) begin
        deb_d = s1_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q  <= 1'b0;
      s1_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb  = deb_q;
  assign rise = deb_d & ~deb_q;

endmodule

// File: rtl/button_debounce_if.sv
// Memory-mapped push-button interface: per-channel synchronise/debounce,
// rising-edge press detection, sticky press-event flags cleared on read.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   btn_raw  : N_BTN raw active-high button inputs
//   bus      : btn_bus_if.slave (rd_en, rd_sel in; data, irq out)
// Build option: define BTN_IRQ_EN to generate a registered irq = |events;
// otherwise irq is tied low (port kept for a stable interface).
module button_debounce_if
  import btn_if_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  btn_bus_if.slave         bus
);

  logic [N_BTN-1:0] deb;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] evt_q, evt_d;
  logic             clr;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .deb    (deb[i]),
      .rise   (rise[i])
    );
  end

  assign clr = bus.rd_en && (bus.rd_sel == BTN_SEL_EVENT);

  // A press completing on the clearing edge survives the clear.
  always_comb begin
    evt_d = (clr ? '0 : evt_q) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  // Level reads keep the unused upper bits at one for software written
  // against the older button port format.
  always_comb begin
    if (bus.rd_sel == BTN_SEL_LEVEL) begin
      bus.data = ({XLEN{1'b1}} << N_BTN) | XLEN'(deb);
    end else begin
      bus.data = XLEN'(evt_q);
    end
  end

`ifdef BTN_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |evt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_if.sv
module tb_button_debounce_if;

  localparam int N  = 5;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;

  btn_bus_if bus ();

  button_debounce_if #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: a level is accepted once the last DC synchronised
  // samples (raw inputs two edges old) all differ from the accepted level.
  bit [N-1:0] hist[$];
  bit [N-1:0] deb_m;
  bit [N-1:0] evt_m;
  bit         irq_m;

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back('0);
    deb_m = '0;
    evt_m = '0;
    irq_m = 1'b0;
  endfunction

  function automatic void model_edge(input bit [N-1:0] raw, input bit clr);
    bit [N-1:0] rise;
    bit         same;
    rise = '0;
    hist.push_back(raw);
    for (int i = 0; i < N; i++) begin
      same = 1'b1;
      for (int k = 0; k < DC; k++)
        if (hist[hist.size() - 3 - k][i] == deb_m[i]) same = 1'b0;
      if (same) begin
        if (!deb_m[i]) rise[i] = 1'b1;
        deb_m[i] = ~deb_m[i];
      end
    end
    evt_m = (clr ? '0 : evt_m) | rise;
`ifdef BTN_IRQ_EN
    irq_m = |evt_m;
`else
    irq_m = 1'b0;
`endif
    while (hist.size() > DC + 4) void'(hist.pop_front());
  endfunction

  function automatic exp_t model_read(input bit sel);
    exp_t e;
    e.data = sel ? {27'd0, evt_m} : {27'h7FF_FFFF, deb_m};
    e.irq  = irq_m;
    return e;
  endfunction

  // One cycle: apply the edge to the model, then drive new inputs and
  // queue the expected response for any read issued this cycle.
  task automatic step(input logic [N-1:0] raw, input logic en,
                      input logic sel, input logic r);
    @(posedge clk);
    if (!rst) model_edge(btn_raw, bus.rd_en && bus.rd_sel);
    #1;
    btn_raw    = raw;
    bus.rd_en  = en;
    bus.rd_sel = sel;
    rst        = r;
    if (r) model_reset();
    if (en) exp_q.push_back(model_read(sel));
  endtask

  task automatic hold(input logic [N-1:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b1, k[0], 1'b0);
  endtask

  // Monitor: every read cycle the DUT's data/irq are compared to the queue.
  always @(negedge clk) begin
    if (bus.rd_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: read with no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.data !== e.data) begin
          failures++;
          $display("FAIL data sel=%0b: got %h expected %h at %0t",
                   bus.rd_sel, bus.data, e.data, $time);
        end
        checks++;
        if (bus.irq !== e.irq) begin
          failures++;
          $display("FAIL irq: got %b expected %b at %0t", bus.irq, e.irq, $time);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] cur;
    int           rem[N];
    rst        = 1'b1;
    btn_raw    = '0;
    bus.rd_en  = 1'b0;
    bus.rd_sel = 1'b0;
    model_reset();

    // Reset, then idle reads of both registers.
    step(5'b00000, 1'b1, 1'b0, 1'b1);
    step(5'b00000, 1'b1, 1'b1, 1'b1);
    hold(5'b00000, 4);

    // Clean press on channel 0; watch every cycle across the latency.
    hold(5'b00001, 10);

    // Glitch of 3 cycles on channel 2, then a 6-cycle pulse.
    hold(5'b00101, 3);
    hold(5'b00001, 8);
    hold(5'b00101, 6);
    hold(5'b00001, 10);

    // Clear, then build evt=00011 and clear it with one read.
    step(5'b00001, 1'b1, 1'b1, 1'b0);
    hold(5'b00000, 8);
    hold(5'b00011, 8);
    step(5'b00011, 1'b1, 1'b1, 1'b0);
    hold(5'b00011, 4);

    // Pending events, then a clearing read on the edge btn[4] completes.
    hold(5'b00000, 8);
    hold(5'b00011, 8);
    step(5'b10011, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(5'b10011, 1'b0, 1'b0, 1'b0);
    step(5'b10011, 1'b1, 1'b1, 1'b0);
    hold(5'b10011, 4);

    // Reset mid-count on btn[3], then the event after full latency.
    step(5'b00000, 1'b1, 1'b1, 1'b0);
    hold(5'b00000, 8);
    step(5'b01000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(5'b01000, 1'b0, 1'b0, 1'b0);
    step(5'b01000, 1'b1, 1'b0, 1'b1);
    step(5'b01000, 1'b1, 1'b1, 1'b1);
    step(5'b01000, 1'b1, 1'b1, 1'b0);
    hold(5'b01000, 9);

    // Randomised hold times around the debounce length.
    cur = '0;
    for (int i = 0; i < N; i++) rem[i] = 1;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          cur[i] = ~cur[i];
          rem[i] = $urandom_range(1, 9);
        end
      end
      step(cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 299) == 0));
    end

    step(cur, 1'b0, 1'b0, 1'b0);
    step(cur, 1'b0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d entries remaining, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
